// File: rtl/pulse_blinker_if.sv
// ---------------------------------------------------------------------------
// pulse_blinker_if
//   Groups the event/status signals of pulse_blinker into one bundle.
//   master : pulse source / status consumer (drives pulse_i, clr_i)
//   slave  : the blinker itself (drives led_o, busy_o, pending_o, overflow_o)
//   Signals:
//     pulse_i    1   event pulse, one event per cycle sampled high
//     clr_i      1   synchronous clear of overflow_o
//     led_o      1   registered LED drive
//     busy_o     1   blinker not idle
//     pending_o  PW  queued blinks not yet started
//     overflow_o 1   sticky: an event was dropped on a full queue
// ---------------------------------------------------------------------------
interface pulse_blinker_if #(
    parameter int MAX_PENDING = 7
);
    localparam int PW = $clog2(MAX_PENDING + 1);

    logic          pulse_i;
    logic          clr_i;
    logic          led_o;
    logic          busy_o;
    logic [PW-1:0] pending_o;
    logic          overflow_o;

    modport master (
        output pulse_i, clr_i,
        input  led_o, busy_o, pending_o, overflow_o
    );

    modport slave (
        input  pulse_i, clr_i,
        output led_o, busy_o, pending_o, overflow_o
    );
endinterface

// File: rtl/pulse_blinker.sv
// ---------------------------------------------------------------------------
// pulse_blinker
//   Turns single-cycle event pulses into human-visible LED blinks. Every
//   accepted pulse produces one blink: LED high for ON_CYCLES, then low for
//   OFF_CYCLES. Pulses arriving while a blink is in progress are queued in a
//   saturating counter so bursts are shown as distinct blinks.
//   Ports:
//     clk_i    1  system clock, rising edge
//     rst_n_i  1  asynchronous active-low reset (aborts blink, drops queue)
//     pb          pulse_blinker_if.slave (pulse_i, clr_i, led_o, busy_o,
//                 pending_o, overflow_o)
// ---------------------------------------------------------------------------
module pulse_blinker #(
    parameter int ON_CYCLES   = 25_000_000,
    parameter int OFF_CYCLES  = 25_000_000,
    parameter int MAX_PENDING = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    pulse_blinker_if.slave        pb
);
    localparam int PW   = $clog2(MAX_PENDING + 1);
    localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    // Timer counts down to zero; loading N-1 gives exactly N edges per phase.
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pend_q,  pend_d;
    logic          ovf_q,   ovf_d;
    logic          led_q,   led_d;
    logic          busy_q,  busy_d;

    logic          start_blink;
    logic          accept;
    logic          drop;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        start_blink = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pend_q != '0) begin
                    state_d     = ST_ON;
                    timer_d     = ON_LOAD;
                    start_blink = 1'b1;
                end
            end
            ST_ON: begin
                if (timer_q == '0) begin
                    state_d = ST_OFF;
                    timer_d = OFF_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_OFF: begin
                // Next queued blink starts right as the gap ends, no IDLE cycle.
                if (timer_q == '0) begin
                    if (pend_q != '0) begin
                        state_d     = ST_ON;
                        timer_d     = ON_LOAD;
                        start_blink = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        // A full queue still accepts a pulse when a blink starts the same
        // cycle: the slot freed by the start is taken by the new event.
        accept = pb.pulse_i && ((pend_q != PEND_MAX) || start_blink);
        drop   = pb.pulse_i && !accept;

        pend_d = pend_q;
        if (accept && !start_blink) begin
            pend_d = pend_q + PW'(1);
        end else if (!accept && start_blink) begin
            pend_d = pend_q - PW'(1);
        end

        // Setting wins over a simultaneous clear so no drop goes unreported.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (pb.clr_i) begin
            ovf_d = 1'b0;
        end

        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign pb.led_o      = led_q;
    assign pb.busy_o     = busy_q;
    assign pb.pending_o  = pend_q;
    assign pb.overflow_o = ovf_q;

endmodule

// File: tb/tb_pulse_blinker.sv
// ---------------------------------------------------------------------------
// tb_pulse_blinker
//   Self-checking bench for pulse_blinker with ON_CYCLES=4, OFF_CYCLES=2,
//   MAX_PENDING=3. Directed vector table, asynchronous reset sequences and a
//   randomized run against a timeline-based reference model.
// ---------------------------------------------------------------------------
module tb_pulse_blinker;
    localparam int ON   = 4;
    localparam int OFF  = 2;
    localparam int MAXP = 3;
    localparam int PW   = $clog2(MAXP + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pulse_blinker_if #(.MAX_PENDING(MAXP)) bus ();

    pulse_blinker #(
        .ON_CYCLES   (ON),
        .OFF_CYCLES  (OFF),
        .MAX_PENDING (MAXP)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .pb      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit pulse;
        bit clr;
        bit led;
        bit busy;
        int pend;
        bit ovf;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the blink is a timeline position counted in edges
    // since the blink started (-1 = nothing showing).
    int m_since;
    int m_pend;
    bit m_ovf;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input bit l, input bit b, input int pd, input bit o);
        check({tag, ".led"},      int'(bus.led_o),      int'(l));
        check({tag, ".busy"},     int'(bus.busy_o),     int'(b));
        check({tag, ".pending"},  int'(bus.pending_o),  pd);
        check({tag, ".overflow"}, int'(bus.overflow_o), int'(o));
    endtask

    function automatic void add(input bit p, input bit c, input bit l, input bit b,
                                input int pd, input bit o, input int n);
        vec_t v;
        v.pulse = p; v.clr = c; v.led = l; v.busy = b; v.pend = pd; v.ovf = o;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic model_reset();
        m_since = -1;
        m_pend  = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input bit p, input bit c);
        bit start;
        bit acc;
        start = 1'b0;
        if (m_since >= 0) begin
            m_since++;
            if (m_since == ON + OFF) m_since = -1;
        end
        if (m_since == -1 && m_pend > 0) begin
            start   = 1'b1;
            m_since = 0;
        end
        acc = p && (m_pend < MAXP || start);
        if (p && !acc) m_ovf = 1'b1;
        else if (c)    m_ovf = 1'b0;
        m_pend = m_pend + (acc ? 1 : 0) - (start ? 1 : 0);
    endtask

    // Drive inputs, take one edge, sample 1 time unit later.
    task automatic cycle(input bit p, input bit c);
        bus.pulse_i = p;
        bus.clr_i   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        bus.pulse_i = 1'b0;
        bus.clr_i   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pulse_i = 1'b0;
        bus.clr_i   = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 0, 1'b0);
        rst_n = 1'b1;

        // Reset mid-run: start a blink, then pull reset between edges.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("midrun.led_before", int'(bus.led_o), 1);
        reset_pulse();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0);
            check_all("post_rst_idle", 1'b0, 1'b0, 0, 1'b0);
        end

        // Directed table: single pulse, 3-pulse burst, pulse in OFF gap,
        // held pulse with overflow and clear.
        add(1,0,0,0,1,0,1); add(0,0,1,1,0,0,4); add(0,0,0,1,0,0,2); add(0,0,0,0,0,0,1);

        add(1,0,0,0,1,0,1); add(1,0,1,1,1,0,1); add(1,0,1,1,2,0,1); add(0,0,1,1,2,0,2);
        add(0,0,0,1,2,0,2); add(0,0,1,1,1,0,4); add(0,0,0,1,1,0,2); add(0,0,1,1,0,0,4);
        add(0,0,0,1,0,0,2); add(0,0,0,0,0,0,1);

        add(1,0,0,0,1,0,1); add(0,0,1,1,0,0,4); add(1,0,0,1,1,0,1); add(0,0,0,1,1,0,1);
        add(0,0,1,1,0,0,4); add(0,0,0,1,0,0,2); add(0,0,0,0,0,0,1);

        add(1,0,0,0,1,0,1); add(1,0,1,1,1,0,1); add(1,0,1,1,2,0,1); add(1,0,1,1,3,0,1);
        add(1,0,1,1,3,1,1); add(1,0,0,1,3,1,1); add(1,1,0,1,3,1,1); add(0,1,1,1,2,0,1);
        add(0,0,1,1,2,0,3); add(0,0,0,1,2,0,2); add(0,0,1,1,1,0,4); add(0,0,0,1,1,0,2);
        add(0,0,1,1,0,0,4); add(0,0,0,1,0,0,2); add(0,0,0,0,0,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].pulse, vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].led, vecs[i].busy, vecs[i].pend, vecs[i].ovf);
        end

        // Reset during ON with two blinks queued.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("on_pend2.led",     int'(bus.led_o),     1);
        check("on_pend2.pending", int'(bus.pending_o), 2);
        reset_pulse();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0);
            check_all("no_blink_after_rst", 1'b0, 1'b0, 0, 1'b0);
        end

        // Randomized run against the reference model, density varying in bursts.
        model_reset();
        begin
            int dens;
            bit p;
            bit c;
            dens = 0;
            for (int i = 0; i < 2000; i++) begin
                if (i % 100 == 0) dens = $urandom_range(0, 7);
                p = ($urandom_range(0, 7) < dens);
                c = ($urandom_range(0, 15) == 0);
                cycle(p, c);
                model_step(p, c);
                check_all("rand", (m_since >= 0 && m_since < ON), (m_since >= 0), m_pend, m_ovf);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pulse_blinker.md
Name: pulse_blinker

Overview:
- Converts single-cycle event pulses (e.g. the output of fsm_pulsos) into human-visible LED blinks.
- Each accepted pulse becomes exactly one blink: LED on for ON_CYCLES, then off for OFF_CYCLES.
- Pulses arriving during a blink are queued in a saturating pending counter, so rapid presses are shown as distinct blinks, not merged.
- Sits between the pulse generator and the board LED in top-level designs.

Parameters:
- ON_CYCLES, 25_000_000: LED high time per blink, in clk cycles (>=1).
- OFF_CYCLES, 25_000_000: mandatory LED low gap after each blink, in clk cycles (>=1).
- MAX_PENDING, 7: maximum queued blinks (>=1); PW = $clog2(MAX_PENDING+1).

Ports:
- clk_i  input  1  system clock, all state on rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- pulse_i  input  1  event pulse; each cycle sampled high counts as one event.
- clr_i  input  1  synchronous clear of overflow_o.
- led_o  output  1  registered LED drive.
- busy_o  output  1  high when FSM not IDLE.
- pending_o  output  PW  queued blinks not yet started.
- overflow_o  output  1  sticky: an event was dropped because the queue was full.

Behaviour:
- Reset (rst_n_i low, async, immediate): state=IDLE, led_o=0, busy_o=0, pending_o=0, overflow_o=0, timer=0. Reset mid-blink aborts the blink and drops the queue.
- Timer width: $clog2(max(ON_CYCLES,OFF_CYCLES)).
- Pending counter, per edge:
  - inc = pulse_i && (pending<MAX_PENDING);
  - dec = FSM entering ON;
  - inc and dec in the same cycle: net unchanged;
  - pulse_i while pending==MAX_PENDING and no dec: event dropped, overflow_o<=1;
  - pulse_i with pending==MAX_PENDING and dec in the same cycle: accepted, pending stays MAX_PENDING, no overflow.
- overflow_o: set as above; cleared only by clr_i (sync) or reset. Set has priority over clr_i in the same cycle.
- FSM states: IDLE, ON, OFF.
  - IDLE: led_o=0. If pending>0 -> ON (load timer, dec pending).
  - ON: led_o=1 for exactly ON_CYCLES edges, then -> OFF (load timer).
  - OFF: led_o=0 for exactly OFF_CYCLES edges, then -> ON if pending>0 (dec), else -> IDLE.
  - No ON-to-ON transition without a full OFF gap.
- Latency: pulse_i high in cycle k (sampled at edge E_k), FSM idle:
  - pending_o=1 after E_k;
  - at E_k+1: led_o=1 and pending_o=0;
  - led_o falls at E_k+1+ON_CYCLES.
  - Blink period for back-to-back queued events: ON_CYCLES+OFF_CYCLES.
- busy_o = (state!=IDLE), registered with state.
- led_o is a flop output, glitch-free; no combinational path from pulse_i to led_o.
- pulse_i is assumed synchronous to clk_i (already synchronized upstream).

Test Plan (ON_CYCLES=4, OFF_CYCLES=2, MAX_PENDING=3):
1. Assert rst_n_i=0 mid-run -> all outputs 0 immediately (no clock); release -> stay 0 with pulse_i=0 for 20 cycles.
2. Single pulse at E0 -> pending_o=1 after E0; led_o=1 after E1..E4, 0 after E5; busy_o falls after E7; pending_o=0; overflow_o=0.
3. Pulses at E0, E1, E2 -> exactly 3 blinks, rising at E1, E7, E13, each 4 cycles high; pending_o sequence after E0..E2 = 1,1,2; returns IDLE after E19.
4. Pulse held high 6 cycles from E0 -> pending saturates at 3 (one dec at E1); overflow_o=1 by E5; 4 blinks total. clr_i pulse -> overflow_o=0 next edge. clr_i and a dropped pulse in the same cycle -> overflow_o stays 1.
5. Single pulse landing during OFF gap of a blink -> next blink rises on the edge the gap ends (no IDLE cycle between).
6. rst_n_i low during ON with pending_o=2 -> led_o=0 and pending_o=0 asynchronously; after release no further blinks occur.
